truth_table_sequencer: RTL and testbench

Sequencing controller for the small combinational gate blocks in this codebase, such as the SOP gate with minterms 1, 3, 4 and 6, where F = A ^ C. It sweeps the gate inputs through all 2^N input combinations and waits a programmable settle time before sampling F at each one. The samples build a minterm mask, which is compared against an expected mask to give a pass/fail result and the index of the first failing minterm. It sits between a test/config source (START) and the gate under control (VEC drives the gate inputs, F_IN returns the gate output).

---
 rtl/truth_table_sequencer_pkg.sv | 17 +
 rtl/truth_table_sequencer_lowest_set_index.sv | 19 +
 rtl/truth_table_sequencer.sv | 115 +++++++++++
 tb/tb_truth_table_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and default constants for the truth-table sequencer.
package truth_table_sequencer_pkg;

  // Default gate width and its expected minterm mask (F = A ^ C -> minterms 1,3,4,6).
  localparam int N_INPUTS_DEF = 3;
  localparam int MASK_W_DEF   = 1 << N_INPUTS_DEF;
  localparam logic [MASK_W_DEF-1:0] EXPECTED_DEF = 8'h5A;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/truth_table_sequencer_lowest_set_index.sv
// Priority encoder: index of the lowest set bit, 0 when no bit is set.
module lowest_set_index #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 3
) (
  input  logic [IN_W-1:0]  in_bits,
  output logic [OUT_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    idx = '0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (in_bits[i]) idx = OUT_W'(i);
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps a combinational gate through every input combination, waits a settle
// time per vector, samples F into a minterm mask and compares against EXPECTED.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_INPUTS      = N_INPUTS_DEF,
  parameter int SETTLE_CYCLES = 1,
  parameter logic [(1 << N_INPUTS)-1:0] EXPECTED = EXPECTED_DEF,
  localparam int MASK_W = 1 << N_INPUTS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                F_IN,
  output logic [N_INPUTS-1:0] VEC,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS,
  output logic [MASK_W-1:0]   MASK,
  output logic [MASK_W-1:0]   MISMATCH,
  output logic [N_INPUTS-1:0] FAIL_IDX
);

  // Settle counter only needs to reach SETTLE_CYCLES-1.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_VEC = '1;

  state_e              state_q, state_d;
  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic                valid_q, valid_d;

  // Next-state logic: settle each vector, sample F, advance or finish.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          mask_d  = '0;
          valid_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        mask_d[vec_q] = F_IN;
        if (vec_q == LAST_VEC) begin
          // Result becomes valid together with the final sample, so PASS is
          // already meaningful during the DONE cycle.
          state_d = ST_DONE;
          valid_d = 1'b1;
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + N_INPUTS'(1);
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (RST) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      // NOTE: the mask register is reset too, so a reset never exposes a stale result.
      mask_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
    end
  end

  assign VEC      = vec_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = (state_q == ST_DONE);
  assign MASK     = mask_q;
  assign PASS     = valid_q & (mask_q == EXPECTED);
  assign MISMATCH = valid_q ? (mask_q ^ EXPECTED) : '0;

  lowest_set_index #(
    .IN_W  (MASK_W),
    .OUT_W (N_INPUTS)
  ) u_lowest_set_index (
    .in_bits (MISMATCH),
    .idx     (FAIL_IDX)
  );

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer: directed and random gate
// functions compared against a behavioural truth-table model.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, start3;
  logic       f_in, f_in3;
  logic [2:0] vec, vec3;
  logic       busy, busy3, done, done3, pass, pass3;
  logic [7:0] mask, mask3, mis, mis3;
  logic [2:0] fidx, fidx3;

  int         mode;
  logic [7:0] tt;
  bit         sel3;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  truth_table_sequencer u_dut (
    .CLK(clk), .RST(rst), .START(start), .F_IN(f_in), .VEC(vec),
    .BUSY(busy), .DONE(done), .PASS(pass), .MASK(mask),
    .MISMATCH(mis), .FAIL_IDX(fidx)
  );

  truth_table_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
    .CLK(clk), .RST(rst), .START(start3), .F_IN(f_in3), .VEC(vec3),
    .BUSY(busy3), .DONE(done3), .PASS(pass3), .MASK(mask3),
    .MISMATCH(mis3), .FAIL_IDX(fidx3)
  );

  // Controlled gate for the default instance.
  always_comb begin
    case (mode)
      0:       f_in = vec[2] ^ vec[0];
      1:       f_in = 1'b0;
      2:       f_in = (vec[2] ^ vec[0]) | (&vec);
      default: f_in = tt[vec];
    endcase
  end

  // Gate with two cycles of latency for the slow-settle instance.
  logic [2:0] vec3_d1, vec3_d2;
  always @(posedge clk) begin
    vec3_d1 <= vec3;
    vec3_d2 <= vec3_d1;
  end
  assign f_in3 = vec3_d2[2] ^ vec3_d2[0];

  // Observed view of whichever instance is under test.
  logic [2:0] m_vec, m_fidx;
  logic       m_busy, m_done, m_pass;
  logic [7:0] m_mask, m_mis;
  assign m_vec  = sel3 ? vec3  : vec;
  assign m_busy = sel3 ? busy3 : busy;
  assign m_done = sel3 ? done3 : done;
  assign m_pass = sel3 ? pass3 : pass;
  assign m_mask = sel3 ? mask3 : mask;
  assign m_mis  = sel3 ? mis3  : mis;
  assign m_fidx = sel3 ? fidx3 : fidx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: value of the gate function at minterm index idx = {A,B,C}.
  function automatic logic model_bit(input int md, input logic [7:0] t, input int idx);
    int a = (idx >> 2) & 1;
    int b = (idx >> 1) & 1;
    int c = idx & 1;
    case (md)
      0:       return logic'(a ^ c);
      1:       return 1'b0;
      2:       return logic'((a ^ c) | (a & b & c));
      default: return t[idx];
    endcase
  endfunction

  function automatic logic [7:0] model_mask(input int md, input logic [7:0] t);
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) m[i] = model_bit(md, t, i);
    return m;
  endfunction

  // Compare the DONE-cycle result against the model built from an expected mask.
  task automatic check_result(input string tag, input logic [7:0] exp_mask);
    logic [7:0] exp_mis = exp_mask ^ 8'h5A;
    int         exp_idx = 0;
    bit         found = 0;
    for (int i = 0; i < 8; i++) begin
      if (exp_mis[i] && !found) begin
        exp_idx = i;
        found   = 1;
      end
    end
    check({tag, "_mask"}, m_mask, exp_mask);
    check({tag, "_pass"}, m_pass, exp_mask == 8'h5A);
    check({tag, "_mis"},  m_mis,  exp_mis);
    check({tag, "_fidx"}, m_fidx, exp_idx);
  endtask

  task automatic set_start(input bit s3, input logic v);
    if (s3) start3 = v;
    else    start  = v;
  endtask

  // Caller raises START in cycle k; returns with the bench sitting in the
  // DONE cycle (lat = cycles after k) or lat = -1 on timeout.
  task automatic run_sweep(input bit s3, input int settle, input bit hold, input bit spam,
                           output int lat, output bit vec_ok, output bit busy_ok);
    int per   = settle + 1;
    int total = 8 * per;
    lat     = -1;
    vec_ok  = 1;
    busy_ok = 1;
    for (int c = 1; c <= total + 10; c++) begin
      tick();
      if (!hold) set_start(s3, (spam && c < total) ? logic'($urandom_range(0, 1)) : 1'b0);
      if (m_done) begin
        lat = c;
        break;
      end
      if (c <= total) begin
        if (m_vec !== 3'((c - 1) / per)) vec_ok = 0;
        if (m_busy !== 1'b1) busy_ok = 0;
      end
    end
    if (!hold) set_start(s3, 1'b0);
  endtask

  initial begin
    int         lat;
    bit         vok, bok;
    int         done_at[$];
    bit         hit;
    logic [7:0] em;

    rst = 1; start = 0; start3 = 0; mode = 0; tt = '0; sel3 = 0;
    repeat (3) tick();

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vec",  vec,  0);
    check("rst_mask", mask, 0);
    check("rst_pass", pass, 0);
    check("rst_mis",  mis,  0);
    check("rst_fidx", fidx, 0);

    // Reset dominates a simultaneous START.
    start = 1;
    tick();
    check("rst_vs_start_busy", busy, 0);
    rst = 0; start = 0;
    tick();
    check("idle_no_start_busy", busy, 0);

    // Correct gate: full sweep timing, vector sequence and PASS.
    mode = 0; start = 1;
    run_sweep(0, 1, 0, 0, lat, vok, bok);
    check("t1_done_lat", lat, 17);
    check("t1_vec_seq",  vok, 1);
    check("t1_busy",     bok, 1);
    check("t1_done_busy", busy, 1);
    check_result("t1", model_mask(0, tt));
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_hold_pass",  pass, model_mask(0, tt) == 8'h5A);
    check("t1_hold_vec",   vec,  7);
    check("t1_idle_busy",  busy, 0);

    // Stuck-at-0 gate.
    mode = 1; start = 1;
    run_sweep(0, 1, 0, 0, lat, vok, bok);
    check("t2_done_lat", lat, 17);
    check_result("t2", model_mask(1, tt));
    tick();

    // Gate with an extra minterm 7.
    mode = 2; start = 1;
    run_sweep(0, 1, 0, 0, lat, vok, bok);
    check("t3_done_lat", lat, 17);
    check_result("t3", model_mask(2, tt));
    tick();

    // Reset in the middle of a sweep, then a clean sweep.
    mode = 0; start = 1;
    tick();
    start = 0;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (vec == 3'd4) begin
        hit = 1;
        break;
      end
      tick();
    end
    check("t4_reached_vec4", hit, 1);
    rst = 1;
    tick();
    rst = 0;
    check("t4_busy", busy, 0);
    check("t4_vec",  vec,  0);
    check("t4_mask", mask, 0);
    check("t4_pass", pass, 0);
    check("t4_mis",  mis,  0);
    start = 1;
    run_sweep(0, 1, 0, 0, lat, vok, bok);
    check("t4b_done_lat", lat, 17);
    check_result("t4b", model_mask(0, tt));
    tick();

    // START held high for 40 cycles: back-to-back sweeps.
    start = 1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) begin
        done_at.push_back(c);
        check("t5_pass_at_done", pass, 1);
      end
    end
    start = 0;
    check("t5_num_done", done_at.size(), 2);
    if (done_at.size() == 2) begin
      check("t5_done0", done_at[0], 17);
      check("t5_done1", done_at[1], 35);
    end
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        hit = 1;
        break;
      end
      tick();
    end
    check("t5_back_to_idle", hit, 1);

    // Random START pulses while busy must not restart or extend the sweep.
    start = 1;
    run_sweep(0, 1, 0, 1, lat, vok, bok);
    check("t6_done_lat", lat, 17);
    check("t6_vec_seq",  vok, 1);
    check_result("t6", model_mask(0, tt));
    tick();
    tick();

    // Random gate functions against the truth-table model.
    mode = 3;
    for (int r = 0; r < 6; r++) begin
      tt = 8'($urandom);
      if (r == 0) tt = 8'h5A;
      em = model_mask(3, tt);
      start = 1;
      run_sweep(0, 1, 0, 0, lat, vok, bok);
      check($sformatf("rnd%0d_lat", r), lat, 17);
      check_result($sformatf("rnd%0d", r), em);
      tick();
    end

    // Slow gate: SETTLE_CYCLES=3 with a two-cycle-latency A^C.
    sel3 = 1; start3 = 1;
    run_sweep(1, 3, 0, 0, lat, vok, bok);
    check("t7_done_lat", lat, 33);
    check("t7_vec_seq",  vok, 1);
    check("t7_busy",     bok, 1);
    check_result("t7", model_mask(0, tt));
    tick();
    sel3 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
